// File: rtl/exu_issue.sv
// exu_issue: ID->EX issue stage with operand select, registered output slot and one-entry skid buffer.
// Optional writeback forwarding into register operands is enabled by defining EXU_ISSUE_FWD_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 5
`endif
module exu_issue #(
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ARGS_W = `ARGS_WIDTH,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  output logic              o_id_ready,
  input  logic [ARGS_W-1:0] i_id_alu_type,
  input  logic [1:0]        i_id_rs1_sel,
  input  logic [1:0]        i_id_rs2_sel,
  input  logic [REG_AW-1:0] i_id_rs1_idx,
  input  logic [REG_AW-1:0] i_id_rs2_idx,
  input  logic [DATA_W-1:0] i_id_rs1_data,
  input  logic [DATA_W-1:0] i_id_rs2_data,
  input  logic [DATA_W-1:0] i_id_imm,
  input  logic [DATA_W-1:0] i_id_pc,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_wen,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_flush,
  output logic              o_ex_valid,
  input  logic              i_ex_ready,
  output logic [ARGS_W-1:0] o_ex_alu_type,
  output logic [DATA_W-1:0] o_ex_rs1_data,
  output logic [DATA_W-1:0] o_ex_rs2_data,
  output logic [DATA_W-1:0] o_ex_pc,
  output logic [DATA_W-1:0] o_ex_imm,
  output logic [REG_AW-1:0] o_ex_rd,
  output logic              o_ex_wen
);
  typedef struct packed {
    logic              vld;
    logic [ARGS_W-1:0] alu;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic [1:0]        rs1_sel;
    logic [1:0]        rs2_sel;
    logic [REG_AW-1:0] rd;
    logic              wen;
  } entry_t;
  entry_t out_q, out_d, skid_q, skid_d, cap;
  logic rdy_q, rdy_d, acc, out_free;
`ifdef EXU_ISSUE_FWD_EN
  function automatic entry_t fwd(input entry_t e);
    entry_t r;
    r = e;
    if (i_wb_en && i_wb_rd != '0) begin
      if (e.rs1_sel == 2'd0 && e.rs1_idx == i_wb_rd) r.op1 = i_wb_data;
      if (e.rs2_sel == 2'd0 && e.rs2_idx == i_wb_rd) r.op2 = i_wb_data;
    end
    return r;
  endfunction
`else
  function automatic entry_t fwd(input entry_t e);
    return e;
  endfunction
  logic unused_wb;
  assign unused_wb = ^{i_wb_en, i_wb_rd, i_wb_data};
`endif
  always_comb begin
    acc = i_id_valid & rdy_q;
    out_free = !out_q.vld | i_ex_ready;
    cap = '0;
    cap.vld = acc;
    cap.alu = i_id_alu_type;
    cap.op1 = i_id_rs1_sel == 2'd0 ? i_id_rs1_data : i_id_rs1_sel == 2'd1 ? i_id_pc : '0;
    cap.op2 = i_id_rs2_sel == 2'd0 ? i_id_rs2_data : i_id_rs2_sel == 2'd1 ? i_id_imm :
              i_id_rs2_sel == 2'd2 ? DATA_W'(4) : '0;
    cap.pc = i_id_pc;
    cap.imm = i_id_imm;
    cap.rs1_idx = i_id_rs1_idx;
    cap.rs2_idx = i_id_rs2_idx;
    cap.rs1_sel = i_id_rs1_sel;
    cap.rs2_sel = i_id_rs2_sel;
    cap.rd = i_id_rd;
    cap.wen = i_id_wen;
    cap = fwd(cap);
    // Held entries keep their data while stalled, except for forwarding updates
    if (out_free) begin
      out_d = skid_q.vld ? fwd(skid_q) : cap;
      skid_d = cap;
      skid_d.vld = skid_q.vld & acc;
    end else begin
      out_d = fwd(out_q);
      skid_d = acc ? cap : fwd(skid_q);
    end
    if (i_flush) begin
      out_d.vld = 1'b0;
      skid_d.vld = 1'b0;
    end
    rdy_d = !skid_d.vld;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q <= '0;
      skid_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      rdy_q <= rdy_d;
    end
  end
  assign o_id_ready = rdy_q;
  assign o_ex_valid = out_q.vld;
  assign o_ex_alu_type = out_q.alu;
  assign o_ex_rs1_data = out_q.op1;
  assign o_ex_rs2_data = out_q.op2;
  assign o_ex_pc = out_q.pc;
  assign o_ex_imm = out_q.imm;
  assign o_ex_rd = out_q.rd;
  assign o_ex_wen = out_q.wen;
endmodule

// File: tb/tb_exu_issue.sv
// tb_exu_issue: scoreboard bench for exu_issue; accepted instructions queue expectations, a monitor checks each issue.
module tb_exu_issue;
  logic i_clk = 0, i_rst_n = 0;
  logic i_id_valid = 0, o_id_ready;
  logic [4:0] i_id_alu_type = 0;
  logic [1:0] i_id_rs1_sel = 0, i_id_rs2_sel = 0;
  logic [4:0] i_id_rs1_idx = 0, i_id_rs2_idx = 0, i_id_rd = 0, i_wb_rd = 0;
  logic [31:0] i_id_rs1_data = 0, i_id_rs2_data = 0, i_id_imm = 0, i_id_pc = 0, i_wb_data = 0;
  logic i_id_wen = 0, i_wb_en = 0, i_flush = 0, i_ex_ready = 1;
  logic o_ex_valid, o_ex_wen;
  logic [4:0] o_ex_alu_type, o_ex_rd;
  logic [31:0] o_ex_rs1_data, o_ex_rs2_data, o_ex_pc, o_ex_imm;
  typedef struct packed {
    logic [4:0]  alu;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;
  exp_t sb[$];
  exp_t me, mg;
  int pop_cyc[$];
  int checks = 0, fails = 0, cyc = 0;
  exu_issue #(.DATA_W(32), .ARGS_W(5), .REG_AW(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_id_alu_type(i_id_alu_type), .i_id_rs1_sel(i_id_rs1_sel), .i_id_rs2_sel(i_id_rs2_sel),
    .i_id_rs1_idx(i_id_rs1_idx), .i_id_rs2_idx(i_id_rs2_idx), .i_id_rs1_data(i_id_rs1_data),
    .i_id_rs2_data(i_id_rs2_data), .i_id_imm(i_id_imm), .i_id_pc(i_id_pc), .i_id_rd(i_id_rd),
    .i_id_wen(i_id_wen), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_flush(i_flush), .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
    .o_ex_alu_type(o_ex_alu_type), .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
    .o_ex_pc(o_ex_pc), .o_ex_imm(o_ex_imm), .o_ex_rd(o_ex_rd), .o_ex_wen(o_ex_wen)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge i_clk);
    if (i_rst_n && o_ex_valid && i_ex_ready) begin
      checks++;
      pop_cyc.push_back(cyc);
      mg = '{o_ex_alu_type, o_ex_rs1_data, o_ex_rs2_data, o_ex_pc, o_ex_imm, o_ex_rd, o_ex_wen};
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue got alu=%0d op1=%h op2=%h, required no issue", mg.alu, mg.op1, mg.op2);
      end else begin
        me = sb.pop_front();
        if (mg !== me) begin
          fails++;
          $display("FAIL ex_txn got alu=%0d op1=%h op2=%h pc=%h imm=%h rd=%0d wen=%b, required alu=%0d op1=%h op2=%h pc=%h imm=%h rd=%0d wen=%b",
                   mg.alu, mg.op1, mg.op2, mg.pc, mg.imm, mg.rd, mg.wen, me.alu, me.op1, me.op2, me.pc, me.imm, me.rd, me.wen);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask
  task automatic issue(input logic [4:0] alu, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [4:0] x1, input logic [4:0] x2, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                       input logic [31:0] e1, input logic [31:0] e2, input bit push);
    int n = 0;
    i_id_valid = 1; i_id_alu_type = alu; i_id_rs1_sel = s1; i_id_rs2_sel = s2;
    i_id_rs1_idx = x1; i_id_rs2_idx = x2; i_id_rs1_data = d1; i_id_rs2_data = d2;
    i_id_imm = imm; i_id_pc = pc; i_id_rd = rd; i_id_wen = wen;
    @(negedge i_clk);
    while (!o_id_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_id_ready) begin
      checks++;
      fails++;
      $display("FAIL issue_timeout got ready=0 required ready=1 for alu=%0d", alu);
      i_id_valid = 0;
    end else begin
      @(posedge i_clk);
      if (push) sb.push_back('{alu, e1, e2, pc, imm, rd, wen});
    end
    #1;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask
  initial begin
    tick(2);
    chk("rst_ex_valid", o_ex_valid, 0);
    chk("rst_id_ready", o_id_ready, 0);
    chk("rst_rs1_data", o_ex_rs1_data, 0);
    #3 i_rst_n = 1;
    @(posedge i_clk); #1;
    chk("ready_after_rst", o_id_ready, 1);
    issue(1, 0, 0, 1, 2, 32'd5, 32'd7, 0, 32'h100, 9, 1, 32'd5, 32'd7, 1);
    i_id_valid = 0;
    chk("add_valid", o_ex_valid, 1);
    chk("add_rs1", o_ex_rs1_data, 5);
    chk("add_rs2", o_ex_rs2_data, 7);
    issue(2, 1, 2, 0, 0, 32'hdead, 32'hbeef, 32'h123, 32'h80000010, 1, 1, 32'h80000010, 32'd4, 1);
    chk("pc_rs1", o_ex_rs1_data, 32'h80000010);
    chk("four_rs2", o_ex_rs2_data, 4);
    issue(3, 2, 1, 4, 5, 32'h99, 32'h98, 32'hfffffff0, 32'h104, 2, 0, 32'h0, 32'hfffffff0, 1);
    issue(4, 3, 3, 6, 7, 32'h55, 32'h66, 32'h77, 32'h108, 3, 1, 32'h0, 32'h0, 1);
    i_id_valid = 0;
    tick(2);
    i_ex_ready = 0;
    issue(5, 0, 0, 1, 2, 32'h10, 32'h20, 0, 32'h200, 4, 1, 32'h10, 32'h20, 1);
    issue(6, 0, 1, 1, 2, 32'h11, 32'h21, 32'h30, 32'h204, 5, 1, 32'h11, 32'h30, 1);
    fork
      issue(7, 0, 0, 1, 2, 32'h40, 32'h50, 0, 32'h208, 6, 0, 32'h40, 32'h50, 1);
      begin
        @(negedge i_clk);
        @(negedge i_clk);
        chk("bp_id_ready", o_id_ready, 0);
        chk("bp_ex_valid", o_ex_valid, 1);
        chk("bp_out_is_a", o_ex_rs1_data, 32'h10);
        @(posedge i_clk); #1;
        i_ex_ready = 1;
      end
    join
    i_id_valid = 0;
    tick(3);
    chk("bp_no_gap", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-3], 2);
    i_ex_ready = 0;
    issue(8, 0, 0, 1, 2, 32'hd1, 32'hd2, 0, 32'h300, 7, 1, 0, 0, 0);
    issue(9, 0, 0, 1, 2, 32'he1, 32'he2, 0, 32'h304, 8, 1, 0, 0, 0);
    i_id_alu_type = 10; i_id_rs1_data = 32'hf1;
    i_flush = 1;
    tick(1);
    i_flush = 0; i_id_valid = 0;
    chk("flush_ex_valid", o_ex_valid, 0);
    chk("flush_id_ready", o_id_ready, 1);
    i_ex_ready = 1;
    i_id_valid = 1; i_flush = 1; i_id_alu_type = 11;
    tick(1);
    i_flush = 0; i_id_valid = 0;
    chk("flush_accept_dropped", o_ex_valid, 0);
    tick(3);
`ifdef EXU_ISSUE_FWD_EN
    i_ex_ready = 0;
    issue(12, 0, 0, 0, 3, 32'h22, 32'h11, 0, 32'h400, 9, 1, 32'h22, 32'hab, 1);
    i_id_valid = 0;
    i_wb_en = 1; i_wb_rd = 0; i_wb_data = 32'h55;
    tick(1);
    chk("fwd_rd0_rs1", o_ex_rs1_data, 32'h22);
    chk("fwd_rd0_rs2", o_ex_rs2_data, 32'h11);
    i_wb_rd = 3; i_wb_data = 32'hab;
    tick(1);
    i_wb_en = 0;
    chk("fwd_held_rs2", o_ex_rs2_data, 32'hab);
    i_ex_ready = 1;
    tick(2);
`endif
    i_ex_ready = 0;
    issue(13, 0, 0, 1, 2, 32'h31, 32'h32, 0, 32'h500, 10, 1, 0, 0, 0);
    i_id_valid = 0;
    @(negedge i_clk);
    #2 i_rst_n = 0;
    #1;
    chk("async_rst_ex_valid", o_ex_valid, 0);
    chk("async_rst_id_ready", o_id_ready, 0);
    #3 i_rst_n = 1;
    i_ex_ready = 1;
    @(posedge i_clk); #1;
    chk("rerst_id_ready", o_id_ready, 1);
    issue(14, 0, 0, 1, 2, 32'h77, 32'h88, 0, 32'h600, 11, 0, 32'h77, 32'h88, 1);
    i_id_valid = 0;
    chk("rerst_ex_valid", o_ex_valid, 1);
    chk("rerst_rs1", o_ex_rs1_data, 32'h77);
    tick(3);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
